// File: rtl/ks10_arb_pkg.sv
// Shared types, slot numbering and routing rules for the KS10 backplane arbiter.
// Initiator slots: 0=CSL, 1..NUBA=UBA, NUBA+1=CPU. Target slots: 0=MEM, 1..NUBA=UBA, NUBA+1=CSL.
package ks10_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arbState_e;

    localparam int MAX_NUBA = 8;
    localparam int MAX_NTGT = MAX_NUBA + 2;

    localparam int INI_CSL = 0;
    localparam int TGT_MEM = 0;

    function automatic int INI_CPU(input int nUba);
        return nUba + 1;
    endfunction

    function automatic int TGT_CSL(input int nUba);
        return nUba + 1;
    endfunction

    // Targets that see tgt_req for a given initiator; bits above NUBA+1 are always zero.
    function automatic logic [MAX_NTGT-1:0] routeMask(input int ini, input int nUba);
        logic [MAX_NTGT-1:0] memBit;
        logic [MAX_NTGT-1:0] ubaBits;
        logic [MAX_NTGT-1:0] cslBit;
        logic                isCsl;
        logic                isCpu;
        memBit  = MAX_NTGT'(1) << TGT_MEM;
        ubaBits = ((MAX_NTGT'(1) << nUba) - MAX_NTGT'(1)) << 1;
        cslBit  = MAX_NTGT'(1) << TGT_CSL(nUba);
        isCsl   = (ini == INI_CSL);
        isCpu   = (ini == INI_CPU(nUba));
        return memBit | ((isCsl || isCpu) ? ubaBits : '0) | (isCpu ? cslBit : '0);
    endfunction

endpackage

// File: rtl/ks10_rr_pick.sv
// Round-robin picker: searches req starting one past rrPtr, wrapping modulo N.
module ks10_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [W-1:0] rrPtr,
    input  logic [N-1:0] req,
    output logic         grantValid,
    output logic [W-1:0] grantIdx
);

    logic [W-1:0] idx;

    // Walk the search order backwards so the nearest requester after rrPtr is the last written.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        idx        = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(rrPtr) + k) % N);
            if (req[idx]) begin
                grantValid = 1'b1;
                grantIdx   = idx;
            end
        end
    end

endmodule

// File: rtl/ks10_arb_rr.sv
// Registered KS10 backplane arbiter: CSL > round-robin UBAs > CPU, with CPU
// anti-starvation and a no-ack timeout that completes the cycle with zero data.
module ks10_arb_rr
    import ks10_arb_pkg::*;
#(
    parameter int NUBA       = 4,
    parameter int TIMEOUT    = 63,
    parameter int CPU_STARVE = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUBA+1:0]        ini_req,
    input  logic [(NUBA+2)*36-1:0] ini_addr,
    input  logic [(NUBA+2)*36-1:0] ini_wdata,
    output logic [NUBA+1:0]        ini_ack,
    output logic [35:0]            ini_rdata,
    output logic                   ini_nxm,
    output logic [NUBA+1:0]        tgt_req,
    output logic [35:0]            tgt_addr,
    output logic [35:0]            tgt_wdata,
    input  logic [NUBA+1:0]        tgt_ack,
    input  logic [(NUBA+2)*36-1:0] tgt_rdata,
    input  logic [NUBA*7-1:0]      uba_intr,
    output logic [6:0]             cpu_intr,
    output logic [1:0]             dbgState
);

    localparam int NINI     = NUBA + 2;
    localparam int NTGT     = NUBA + 2;
    localparam int IW       = $clog2(NINI);
    localparam int UW       = (NUBA > 1) ? $clog2(NUBA) : 1;
    localparam int TW       = $clog2(TIMEOUT + 1);
    localparam int SW       = $clog2(CPU_STARVE + 1);
    localparam int CPU_SLOT = INI_CPU(NUBA);
    localparam logic [IW-1:0] CPU_IDX = IW'(CPU_SLOT);
    localparam logic [IW-1:0] CSL_IDX = IW'(INI_CSL);

    // Handshake: an initiator holds ini_req until it sees its one-cycle ini_ack; dropping
    // ini_req while BUSY aborts the cycle. Targets see tgt_req while BUSY and end it with tgt_ack.
    arbState_e     state, nextState;
    logic [IW-1:0] winIdx, selIdx;
    logic          anyReq, cpuStarved, reqHeld, ackHit, timedOut;
    logic [NTGT-1:0] selMask, routeQ, routedAck;
    logic [35:0]   selAddr, selWdata, addrQ, wdataQ, rdataQ, ackData;
    logic          nxmQ;
    logic [UW-1:0] rrPtr, pickIdx;
    logic          pickValid;
    logic [SW-1:0] starveCnt;
    logic [TW-1:0] toCnt;

    ks10_rr_pick #(.N(NUBA), .W(UW)) u_pick (
        .rrPtr      (rrPtr),
        .req        (ini_req[NUBA:1]),
        .grantValid (pickValid),
        .grantIdx   (pickIdx)
    );

    always_comb begin
        anyReq     = |ini_req;
        cpuStarved = (starveCnt == SW'(CPU_STARVE));
        selIdx     = CPU_IDX;
        if (ini_req[INI_CSL])                     selIdx = CSL_IDX;
        else if (ini_req[CPU_SLOT] && cpuStarved) selIdx = CPU_IDX;
        else if (pickValid)                       selIdx = IW'(int'(pickIdx) + 1);
        selMask  = NTGT'(routeMask(int'(selIdx), NUBA));
        selAddr  = '0;
        selWdata = '0;
        reqHeld  = 1'b0;
        for (int i = 0; i < NINI; i++) begin
            if (selIdx == IW'(i)) begin
                selAddr  = ini_addr[i*36 +: 36];
                selWdata = ini_wdata[i*36 +: 36];
            end
            if (winIdx == IW'(i)) reqHeld = ini_req[i];
        end
    end

    // Lowest routed target index wins the data mux: MEM, then UBAs in order, then CSL.
    always_comb begin
        routedAck = tgt_ack & routeQ;
        ackHit    = |routedAck;
        timedOut  = (toCnt == TW'(TIMEOUT));
        ackData   = '0;
        for (int t = NTGT - 1; t >= 0; t--) begin
            if (routedAck[t]) ackData = tgt_rdata[t*36 +: 36];
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = BUSY;
            BUSY: begin
                if (!reqHeld)               nextState = IDLE;
                else if (ackHit || timedOut) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winIdx    <= '0;
            addrQ     <= '0;
            wdataQ    <= '0;
            rdataQ    <= '0;
            nxmQ      <= 1'b0;
            routeQ    <= '0;
            rrPtr     <= UW'(NUBA - 1);
            starveCnt <= '0;
            toCnt     <= '0;
        end else begin
            case (state)
                IDLE: if (anyReq) begin
                    winIdx <= selIdx;
                    addrQ  <= selAddr;
                    wdataQ <= selWdata;
                    routeQ <= selMask;
                    toCnt  <= '0;
                    if (selIdx != CSL_IDX && selIdx != CPU_IDX) rrPtr <= pickIdx;
                    if (ini_req[CPU_SLOT] && selIdx != CPU_IDX) begin
                        if (!cpuStarved) starveCnt <= starveCnt + 1'b1;
                    end else begin
                        starveCnt <= '0;
                    end
                end
                BUSY: begin
                    toCnt <= toCnt + 1'b1;
                    if (nextState == DONE) begin
                        rdataQ <= ackHit ? ackData : '0;
                        nxmQ   <= !ackHit;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NINI; i++) begin
            ini_ack[i] = (state == DONE) && (winIdx == IW'(i));
        end
        cpu_intr = '0;
        for (int u = 0; u < NUBA; u++) begin
            cpu_intr = cpu_intr | uba_intr[u*7 +: 7];
        end
    end

    assign tgt_req   = (state == BUSY) ? routeQ : '0;
    assign ini_rdata = (state == DONE) ? rdataQ : '0;
    assign ini_nxm   = (state == DONE) && nxmQ;
    assign tgt_addr  = addrQ;
    assign tgt_wdata = wdataQ;
    assign dbgState  = state;

endmodule

// File: tb/tb_ks10_arb_rr.sv
// Directed bench for ks10_arb_rr (NUBA=4): vector table for single transactions,
// plus hand-written sequences for timeout, abort, round-robin, starvation and reset.
module tb_ks10_arb_rr;

    localparam int NUBA = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   ini_req = '0;
    logic [215:0] ini_addr = '0;
    logic [215:0] ini_wdata = '0;
    logic [5:0]   ini_ack;
    logic [35:0]  ini_rdata;
    logic         ini_nxm;
    logic [5:0]   tgt_req;
    logic [35:0]  tgt_addr, tgt_wdata;
    logic [5:0]   tgt_ack = '0;
    logic [215:0] tgt_rdata = '0;
    logic [27:0]  uba_intr = '0;
    logic [6:0]   cpu_intr;
    logic [1:0]   dbgState;

    int nChecks = 0;
    int nErrors = 0;
    logic [5:0] exp_q[$];

    typedef struct {
        logic [5:0]  req;
        logic [27:0] intr;
        logic [6:0]  expIntr;
        int          win;
        logic [5:0]  expTgt;
        logic [5:0]  ack;
        int          src;
    } vec_t;
    vec_t vecs[8];

    ks10_arb_rr #(.NUBA(NUBA), .TIMEOUT(63), .CPU_STARVE(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ini_req   (ini_req),
        .ini_addr  (ini_addr),
        .ini_wdata (ini_wdata),
        .ini_ack   (ini_ack),
        .ini_rdata (ini_rdata),
        .ini_nxm   (ini_nxm),
        .tgt_req   (tgt_req),
        .tgt_addr  (tgt_addr),
        .tgt_wdata (tgt_wdata),
        .tgt_ack   (tgt_ack),
        .tgt_rdata (tgt_rdata),
        .uba_intr  (uba_intr),
        .cpu_intr  (cpu_intr),
        .dbgState  (dbgState)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [35:0] slotData(input int t);
        logic [35:0] v;
        v = {4'(t + 1), 32'hCAFE0000 | 32'(t)};
        return v;
    endfunction

    function automatic logic [35:0] addrOf(input int i);
        logic [35:0] v;
        v = {4'hA, 32'(i) * 32'h00010101};
        return v;
    endfunction

    function automatic logic [35:0] wdataOf(input int i);
        logic [35:0] v;
        v = {4'h5, 32'(i) * 32'h00110000};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n   = 1'b0;
        ini_req = '0;
        tgt_ack = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drains exp_q against observed ini_ack pulses; optionally requires MEM-only routing.
    task automatic drainGrants(input int budget, input logic memOnly, input string tag);
        int         cyc;
        logic       routeOk;
        logic [5:0] e;
        cyc     = 0;
        routeOk = 1'b1;
        while (exp_q.size() > 0 && cyc < budget) begin
            tick();
            cyc++;
            if (memOnly && ((tgt_req & 6'b111110) != 6'b000000)) routeOk = 1'b0;
            if (ini_ack != 6'b000000) begin
                e = exp_q.pop_front();
                check({tag, "_grant"}, 64'(ini_ack), 64'(e));
            end
        end
        check({tag, "_budget"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (memOnly) check({tag, "_route"}, 64'(routeOk), 64'd1);
    endtask

    initial begin
        logic [5:0] one;
        logic [5:0] expAck;
        logic       flag;
        int         n;

        one = 6'b000001;
        vecs[0] = '{6'b100000, {7'h01, 7'h02, 7'h04, 7'h08}, 7'h0F, 5, 6'b111111, 6'b110000, 4};
        vecs[1] = '{6'b000001, 28'h0,                        7'h00, 0, 6'b011111, 6'b100110, 1};
        vecs[2] = '{6'b000010, {7'h40, 7'h00, 7'h00, 7'h00}, 7'h40, 1, 6'b000001, 6'b100011, 0};
        vecs[3] = '{6'b011000, {7'h11, 7'h22, 7'h00, 7'h44}, 7'h77, 3, 6'b000001, 6'b000001, 0};
        vecs[4] = '{6'b100001, {7'h00, 7'h7F, 7'h00, 7'h00}, 7'h7F, 0, 6'b011111, 6'b011000, 3};
        vecs[5] = '{6'b100100, {7'h10, 7'h10, 7'h10, 7'h10}, 7'h10, 2, 6'b000001, 6'b000001, 0};
        vecs[6] = '{6'b111111, {7'h00, 7'h00, 7'h03, 7'h05}, 7'h07, 0, 6'b011111, 6'b100001, 0};
        vecs[7] = '{6'b010010, {7'h20, 7'h00, 7'h00, 7'h00}, 7'h20, 1, 6'b000001, 6'b000001, 0};

        for (int i = 0; i < 6; i++) begin
            ini_addr[i*36 +: 36]  = addrOf(i);
            ini_wdata[i*36 +: 36] = wdataOf(i);
            tgt_rdata[i*36 +: 36] = slotData(i);
        end

        // Reset state: everything quiet except the interrupt OR.
        uba_intr = {7'h00, 7'h00, 7'h00, 7'h09};
        repeat (2) @(posedge clk);
        #1;
        check("rst_tgt_req", 64'(tgt_req), 64'd0);
        check("rst_ini_ack", 64'(ini_ack), 64'd0);
        check("rst_nxm", 64'(ini_nxm), 64'd0);
        check("rst_rdata", 64'(ini_rdata), 64'd0);
        check("rst_addr", 64'(tgt_addr), 64'd0);
        check("rst_state", 64'(dbgState), 64'd0);
        check("rst_cpu_intr", 64'(cpu_intr), 64'h09);
        rst_n = 1'b1;

        // Single transactions from reset.
        for (int v = 0; v < 8; v++) begin
            applyReset();
            ini_req  = vecs[v].req;
            uba_intr = vecs[v].intr;
            #1 check($sformatf("vec%0d_intr", v), 64'(cpu_intr), 64'(vecs[v].expIntr));
            tick();
            check($sformatf("vec%0d_tgt_req", v), 64'(tgt_req), 64'(vecs[v].expTgt));
            check($sformatf("vec%0d_addr", v), 64'(tgt_addr), 64'(addrOf(vecs[v].win)));
            tgt_ack = vecs[v].ack;
            tick();
            expAck = one << vecs[v].win;
            check($sformatf("vec%0d_ack", v), 64'(ini_ack), 64'(expAck));
            check($sformatf("vec%0d_rdata", v), 64'(ini_rdata), 64'(slotData(vecs[v].src)));
            check($sformatf("vec%0d_nxm", v), 64'(ini_nxm), 64'd0);
            tgt_ack = '0;
            ini_req = '0;
            tick();
        end

        // CPU read of memory.
        applyReset();
        ini_addr[5*36 +: 36]  = 36'o000000001000;
        ini_wdata[5*36 +: 36] = 36'o777000111222;
        tgt_rdata[0 +: 36]    = 36'o123456765432;
        ini_req = 6'b100000;
        tick();
        check("cpu_tgt_req", 64'(tgt_req), 64'h3F);
        check("cpu_addr", 64'(tgt_addr), 64'(36'o000000001000));
        check("cpu_wdata", 64'(tgt_wdata), 64'(36'o777000111222));
        flag = 1'b1;
        repeat (2) begin
            tick();
            if (ini_ack != 6'b000000) flag = 1'b0;
        end
        tgt_ack = 6'b000001;
        tick();
        check("cpu_no_early_ack", 64'(flag), 64'd1);
        check("cpu_ack", 64'(ini_ack), 64'h20);
        check("cpu_rdata", 64'(ini_rdata), 64'(36'o123456765432));
        check("cpu_nxm", 64'(ini_nxm), 64'd0);
        tgt_ack = '0;
        ini_req = '0;
        tick();
        check("cpu_ack_width", 64'(ini_ack), 64'd0);

        // WRU timeout.
        applyReset();
        ini_req = 6'b100000;
        tick();
        n = 0;
        while (ini_ack == 6'b000000 && n < 100) begin
            tick();
            n++;
        end
        check("to_latency", 64'(n), 64'd64);
        check("to_ack", 64'(ini_ack), 64'h20);
        check("to_rdata", 64'(ini_rdata), 64'd0);
        check("to_nxm", 64'(ini_nxm), 64'd1);
        ini_req = '0;
        tick();

        // CSL preemption, then abort, then the CPU is served.
        applyReset();
        ini_req = 6'b100001;
        tick();
        check("csl_first_tgt", 64'(tgt_req), 64'h1F);
        ini_req = 6'b100000;
        tick();
        check("abort_tgt_req", 64'(tgt_req), 64'd0);
        check("abort_no_ack", 64'(ini_ack), 64'd0);
        tick();
        check("after_abort_cpu_tgt", 64'(tgt_req), 64'h3F);
        tgt_ack = 6'b000001;
        tick();
        check("after_abort_cpu_ack", 64'(ini_ack), 64'h20);
        tgt_ack = '0;
        ini_req = '0;
        tick();

        // UBA round-robin.
        applyReset();
        ini_req = 6'b011110;
        tgt_ack = 6'b000001;
        exp_q.push_back(6'b000010);
        exp_q.push_back(6'b000100);
        exp_q.push_back(6'b001000);
        exp_q.push_back(6'b010000);
        exp_q.push_back(6'b000010);
        drainGrants(40, 1'b1, "rr");

        // CPU anti-starvation.
        applyReset();
        ini_req = 6'b100110;
        tgt_ack = 6'b000001;
        for (int k = 0; k < 7; k++) exp_q.push_back((k % 2 == 0) ? 6'b000010 : 6'b000100);
        exp_q.push_back(6'b100000);
        exp_q.push_back(6'b000100);
        drainGrants(60, 1'b0, "starve");

        // Reset asserted mid-cycle.
        applyReset();
        ini_req = 6'b000100;
        tgt_ack = 6'b000001;
        tick();
        tick();
        check("pre_rst_uba2_ack", 64'(ini_ack), 64'h04);
        ini_req = 6'b100000;
        tgt_ack = '0;
        tick();
        tick();
        check("pre_rst_busy", 64'(tgt_req), 64'h3F);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tgt_req", 64'(tgt_req), 64'd0);
        check("midrst_ini_ack", 64'(ini_ack), 64'd0);
        check("midrst_state", 64'(dbgState), 64'd0);
        ini_req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        flag = 1'b1;
        repeat (4) begin
            tick();
            if (ini_ack != 6'b000000) flag = 1'b0;
        end
        check("postrst_no_ack", 64'(flag), 64'd1);
        ini_req = 6'b001010;
        tgt_ack = 6'b000001;
        exp_q.push_back(6'b000010);
        exp_q.push_back(6'b001000);
        drainGrants(20, 1'b1, "postrst");
        ini_req = '0;
        tgt_ack = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
